// File: rtl/mc_pkg.sv
// Shared types for the multicycle MIPS controller: FSM states,
// opcode/funct codes and datapath mux/ALU encodings.
package mc_pkg;

  typedef logic        u1;
  typedef logic [31:0] u32;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_ADDIEX  = 4'd8,
    S_ADDIWB  = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_aludec.sv
// R-type funct decoder: funct -> alucontrol, plus a legal flag.
// Ports: funct in; alucontrol, legal out.
module mc_aludec
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       legal
);

  always_comb begin
    alucontrol = ALU_AND;
    legal      = 1'b1;
    unique case (1'b1)
      (funct == FN_ADD): alucontrol = ALU_ADD;
      (funct == FN_SUB): alucontrol = ALU_SUB;
      (funct == FN_AND): alucontrol = ALU_AND;
      (funct == FN_OR):  alucontrol = ALU_OR;
      (funct == FN_SLT): alucontrol = ALU_SLT;
      default:           legal      = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM; Moore decode of state to datapath controls.
// Ports: clk, reset, op, funct, zero in; datapath enables/selects, illegal,
// state out. `define PERF_CNT_EN adds cycle_cnt/instret_cnt outputs.
module mips_mc_controller
  import mc_pkg::*;
#(
  parameter state_t RESET_STATE  = S_FETCH,
  parameter bit     TRAP_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
`ifdef PERF_CNT_EN
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt,
`endif
  output logic [3:0] state
);

  state_t     st;
  state_t     nxt;
  u1          pcwrite;
  u1          branch;
  u1          fn_legal;
  logic [2:0] fn_alu;

  mc_aludec u_aludec (
    .funct      (funct),
    .alucontrol (fn_alu),
    .legal      (fn_legal)
  );

  always_ff @(posedge clk) begin
    if (reset) st <= RESET_STATE;
    else       st <= nxt;
  end

  always_comb begin
    nxt        = st;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_B;
    pcsrc      = PC_ALU;
    alucontrol = ALU_AND;
    illegal    = 1'b0;
    case (st)
      S_FETCH: begin
        irwrite    = 1'b1;
        alusrcb    = SRCB_4;
        alucontrol = ALU_ADD;
        pcwrite    = 1'b1;
        nxt        = S_DECODE;
      end
      S_DECODE: begin
        alusrcb    = SRCB_IMMSH;
        alucontrol = ALU_ADD;
        unique case (1'b1)
          (op == OP_LW),
          (op == OP_SW):    nxt = S_MEMADR;
          (op == OP_RTYPE): nxt = S_RTYPEEX;
          (op == OP_ADDI):  nxt = S_ADDIEX;
          (op == OP_BEQ),
          (op == OP_BNE):   nxt = S_BRANCH;
          (op == OP_J):     nxt = S_JUMP;
          default:          nxt = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        alucontrol = ALU_ADD;
        nxt        = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        nxt  = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        nxt      = S_FETCH;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        nxt      = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca    = 1'b1;
        alucontrol = fn_alu;
        nxt        = fn_legal ? S_ALUWB : S_ILLEGAL;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        nxt      = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        alucontrol = ALU_ADD;
        nxt        = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        nxt      = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = PC_ALUOUT;
        branch     = 1'b1;
        nxt        = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = PC_JUMP;
        pcwrite = 1'b1;
        nxt     = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
        nxt     = TRAP_ILLEGAL ? S_ILLEGAL : S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase
  end

  // bne takes the branch when the compare is non-zero
  assign pcen  = pcwrite | (branch & (zero ^ (op == OP_BNE)));
  assign state = st;

`ifdef PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (nxt == S_FETCH && st != S_ILLEGAL)
        instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule
